// File: rtl/pwm_dt_pkg.sv
// Shared constants for the dead-time generator: FSM state codes, CSR offsets, CTRL bit positions
// and the mapping from FSM state to the raw (pre-polarity) high/low leg levels.
package pwm_dt_pkg;

    typedef logic [2:0] dt_state_t;

    localparam dt_state_t ST_IDLE    = 3'd0;
    localparam dt_state_t ST_LOW_ON  = 3'd1;
    localparam dt_state_t ST_DEAD_LH = 3'd2;
    localparam dt_state_t ST_HIGH_ON = 3'd3;
    localparam dt_state_t ST_DEAD_HL = 3'd4;

    localparam logic [7:0] OFS_CTRL   = 8'h00;
    localparam logic [7:0] OFS_DTRISE = 8'h04;
    localparam logic [7:0] OFS_DTFALL = 8'h08;
    localparam logic [7:0] OFS_STAT   = 8'h0C;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_INVH = 1;
    localparam int CTRL_INVL = 2;

    // Returns {high_leg, low_leg}; every state other than the two ON states keeps both legs off.
    function automatic logic [1:0] raw_legs(input dt_state_t st);
        case (st)
            ST_LOW_ON:  return 2'b01;
            ST_HIGH_ON: return 2'b10;
            default:    return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/pwm_dt_csr.sv
// Register block for the dead-time generator: address decode, CTRL/DTRISE/DTFALL storage,
// registered read port and the strobe that clears the swallow counter on any write to STAT.
module pwm_dt_csr
    import pwm_dt_pkg::*;
#(
    parameter int pBlockAdrsMap = 8,
    parameter int pAdrsMap      = 3,
    parameter int pBusAdrsBit   = 15,
    parameter int pDtWidth      = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          wd,
    input  logic [pBusAdrsBit:0] adrs,
    input  logic                 wcke,
    input  dt_state_t            stat_state,
    input  logic [15:0]          swallow_cnt,
    output logic [31:0]          rd,
    output logic                 vd,
    output logic                 en,
    output logic                 inv_h,
    output logic                 inv_l,
    output logic [pDtWidth-1:0]  dt_rise,
    output logic [pDtWidth-1:0]  dt_fall,
    output logic                 cnt_clr
);

    logic                hit;
    logic [7:0]          offset;
    logic [2:0]          ctrl_reg;
    logic [pDtWidth-1:0] dt_rise_reg;
    logic [pDtWidth-1:0] dt_fall_reg;
    logic [31:0]         read_data;
    logic [31:0]         rd_reg;
    logic                vd_reg;
    logic                unused_wd;

    assign hit       = (adrs[pBusAdrsBit -: pBlockAdrsMap] == pBlockAdrsMap'(pAdrsMap));
    assign offset    = adrs[7:0];
    assign cnt_clr   = wcke && hit && (offset == OFS_STAT);
    assign unused_wd = ^wd[31:pDtWidth];

    always_comb begin
        read_data = '0;
        case (offset)
            OFS_CTRL:   read_data[2:0]          = ctrl_reg;
            OFS_DTRISE: read_data[pDtWidth-1:0] = dt_rise_reg;
            OFS_DTFALL: read_data[pDtWidth-1:0] = dt_fall_reg;
            OFS_STAT:   read_data               = {swallow_cnt, 13'd0, stat_state};
            default:    read_data               = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg    <= '0;
            dt_rise_reg <= '0;
            dt_fall_reg <= '0;
            rd_reg      <= '0;
            vd_reg      <= 1'b0;
        end else begin
            if (wcke && hit) begin
                case (offset)
                    OFS_CTRL:   ctrl_reg    <= wd[2:0];
                    OFS_DTRISE: dt_rise_reg <= wd[pDtWidth-1:0];
                    OFS_DTFALL: dt_fall_reg <= wd[pDtWidth-1:0];
                    default:    ;
                endcase
            end
            // A write cycle never returns data, even when it hits this block.
            vd_reg <= hit && !wcke;
            rd_reg <= (hit && !wcke) ? read_data : '0;
        end
    end

    assign rd      = rd_reg;
    assign vd      = vd_reg;
    assign en      = ctrl_reg[CTRL_EN];
    assign inv_h   = ctrl_reg[CTRL_INVH];
    assign inv_l   = ctrl_reg[CTRL_INVL];
    assign dt_rise = dt_rise_reg;
    assign dt_fall = dt_fall_reg;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Turns a single-ended PWM into a complementary half-bridge pair with programmable dead time,
// swallowing input pulses that are shorter than the dead interval.
module pwm_deadtime_gen
    import pwm_dt_pkg::*;
#(
    parameter int pBlockAdrsMap = 8,
    parameter int pAdrsMap      = 3,
    parameter int pBusAdrsBit   = 15,
    parameter int pDtWidth      = 10
) (
    input  logic                 iSysClk,
    input  logic                 iSysRst,
    input  logic                 iPwm,
    output logic                 oPwmH,
    output logic                 oPwmL,
    input  logic [31:0]          iSUsiWd,
    input  logic [pBusAdrsBit:0] iSUsiAdrs,
    input  logic                 iSUsiWCke,
    output logic [31:0]          oSUsiRd,
    output logic                 oSUsiVd
);

    localparam logic [pDtWidth-1:0] DT_ONE = {{(pDtWidth-1){1'b0}}, 1'b1};

    logic                en;
    logic                inv_h;
    logic                inv_l;
    logic [pDtWidth-1:0] dt_rise;
    logic [pDtWidth-1:0] dt_fall;
    logic                cnt_clr;

    logic                rpwm_reg;
    dt_state_t           state_reg, state_next;
    logic [pDtWidth-1:0] dt_cnt_reg, dt_cnt_next;
    logic [15:0]         swallow_reg;
    logic                swallow_inc;
    logic                pwm_h_reg, pwm_l_reg;
    logic [1:0]          legs_next;
    dt_state_t           rise_state, fall_state;

    pwm_dt_csr #(
        .pBlockAdrsMap (pBlockAdrsMap),
        .pAdrsMap      (pAdrsMap),
        .pBusAdrsBit   (pBusAdrsBit),
        .pDtWidth      (pDtWidth)
    ) u_csr (
        .clk         (iSysClk),
        .rst_n       (iSysRst),
        .wd          (iSUsiWd),
        .adrs        (iSUsiAdrs),
        .wcke        (iSUsiWCke),
        .stat_state  (state_reg),
        .swallow_cnt (swallow_reg),
        .rd          (oSUsiRd),
        .vd          (oSUsiVd),
        .en          (en),
        .inv_h       (inv_h),
        .inv_l       (inv_l),
        .dt_rise     (dt_rise),
        .dt_fall     (dt_fall),
        .cnt_clr     (cnt_clr)
    );

    // A zero dead time skips the dead state entirely so the legs swap on the very next cycle.
    // Loading N-1 makes the dead state last exactly N cycles including the expiry cycle.
    assign rise_state = (dt_rise == '0) ? ST_HIGH_ON : ST_DEAD_LH;
    assign fall_state = (dt_fall == '0) ? ST_LOW_ON  : ST_DEAD_HL;

    always_comb begin
        state_next  = state_reg;
        dt_cnt_next = dt_cnt_reg;
        swallow_inc = 1'b0;
        if (!en) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (rpwm_reg) begin
                        state_next  = rise_state;
                        dt_cnt_next = dt_rise - DT_ONE;
                    end else begin
                        state_next  = fall_state;
                        dt_cnt_next = dt_fall - DT_ONE;
                    end
                end
                ST_LOW_ON: begin
                    if (rpwm_reg) begin
                        state_next  = rise_state;
                        dt_cnt_next = dt_rise - DT_ONE;
                    end
                end
                ST_HIGH_ON: begin
                    if (!rpwm_reg) begin
                        state_next  = fall_state;
                        dt_cnt_next = dt_fall - DT_ONE;
                    end
                end
                ST_DEAD_LH: begin
                    if (!rpwm_reg) begin
                        state_next  = ST_LOW_ON;
                        swallow_inc = 1'b1;
                    end else if (dt_cnt_reg == '0) begin
                        state_next = ST_HIGH_ON;
                    end else begin
                        dt_cnt_next = dt_cnt_reg - DT_ONE;
                    end
                end
                ST_DEAD_HL: begin
                    if (rpwm_reg) begin
                        state_next  = ST_HIGH_ON;
                        swallow_inc = 1'b1;
                    end else if (dt_cnt_reg == '0) begin
                        state_next = ST_LOW_ON;
                    end else begin
                        dt_cnt_next = dt_cnt_reg - DT_ONE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign legs_next = raw_legs(state_next);

    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst) begin
            rpwm_reg    <= 1'b0;
            state_reg   <= ST_IDLE;
            dt_cnt_reg  <= '0;
            swallow_reg <= '0;
            pwm_h_reg   <= 1'b0;
            pwm_l_reg   <= 1'b0;
        end else begin
            rpwm_reg   <= iPwm;
            state_reg  <= state_next;
            dt_cnt_reg <= dt_cnt_next;
            if (cnt_clr) begin
                swallow_reg <= '0;
            end else if (swallow_inc && (swallow_reg != 16'hFFFF)) begin
                swallow_reg <= swallow_reg + 16'd1;
            end
            pwm_h_reg <= legs_next[1] ^ inv_h;
            pwm_l_reg <= legs_next[0] ^ inv_l;
        end
    end

    assign oPwmH = pwm_h_reg;
    assign oPwmL = pwm_l_reg;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed and randomized bench for pwm_deadtime_gen; outputs are compared every cycle against a
// run-length reference model of the dead-time rules.
module tb_pwm_deadtime_gen;

    localparam logic [7:0] BLK = 8'h03;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm;
    logic        wcke;
    logic [31:0] wd;
    logic [15:0] adrs;
    logic        pwm_h;
    logic        pwm_l;
    logic [31:0] bus_rd;
    logic        bus_vd;

    int tests = 0;
    int fails = 0;

    // Reference model: committed side m_c, length m_r of the current opposite-level run,
    // dead length m_n latched at the start of that run.
    logic m_en, m_invh, m_invl, m_s, m_c, m_idle, m_h, m_l, m_oinvh, m_oinvl;
    int   m_dtr, m_dtf, m_r, m_n, m_sw, m_sw_pre;

    always #5 clk = ~clk;

    pwm_deadtime_gen dut (
        .iSysClk   (clk),
        .iSysRst   (rst_n),
        .iPwm      (pwm),
        .oPwmH     (pwm_h),
        .oPwmL     (pwm_l),
        .iSUsiWd   (wd),
        .iSUsiAdrs (adrs),
        .iSUsiWCke (wcke),
        .oSUsiRd   (bus_rd),
        .oSUsiVd   (bus_vd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_invh = 0; m_invl = 0; m_s = 0; m_c = 0; m_idle = 1;
        m_h = 0; m_l = 0; m_oinvh = 0; m_oinvl = 0;
        m_dtr = 0; m_dtf = 0; m_r = 0; m_n = 0; m_sw = 0; m_sw_pre = 0;
    endtask

    task automatic model_step();
        logic on_leg;
        logic inc;
        on_leg = 1'b0;
        inc    = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_sw_pre = m_sw;
        m_oinvh  = m_invh;
        m_oinvl  = m_invl;
        if (!m_en) begin
            m_idle = 1;
            m_r    = 0;
        end else begin
            if (m_idle) begin
                m_c    = !m_s;
                m_r    = 0;
                m_idle = 0;
            end
            if (m_s == m_c) begin
                inc    = (m_r > 0);
                m_r    = 0;
                on_leg = 1'b1;
            end else begin
                if (m_r == 0) m_n = m_s ? m_dtr : m_dtf;
                m_r++;
                if (m_r == m_n + 1) begin
                    m_c    = m_s;
                    m_r    = 0;
                    on_leg = 1'b1;
                end
            end
        end
        m_h = (on_leg && m_c) ^ m_oinvh;
        m_l = (on_leg && !m_c) ^ m_oinvl;
        if (wcke && adrs[15:8] == BLK && adrs[7:0] == 8'h0C) m_sw = 0;
        else if (inc && m_sw < 65535) m_sw++;
        if (wcke && adrs[15:8] == BLK) begin
            case (adrs[7:0])
                8'h00:   {m_invl, m_invh, m_en} = wd[2:0];
                8'h04:   m_dtr = int'(wd[9:0]);
                8'h08:   m_dtf = int'(wd[9:0]);
                default: ;
            endcase
        end
        m_s = pwm;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("pwm_h", 32'(pwm_h), 32'(m_h));
        chk("pwm_l", 32'(pwm_l), 32'(m_l));
        chk("overlap", 32'((pwm_h ^ m_oinvh) & (pwm_l ^ m_oinvl)), 32'd0);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] data);
        adrs = a; wd = data; wcke = 1'b1;
        cyc();
        chk("wr_vd", 32'(bus_vd), 32'd0);
        wcke = 1'b0; adrs = 16'h0; wd = 32'h0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] data);
        adrs = a; wcke = 1'b0;
        cyc();
        chk("rd_vd", 32'(bus_vd), 32'd1);
        data = bus_rd;
        adrs = 16'h0;
    endtask

    initial begin
        logic [31:0] d;
        int run;
        model_reset();
        rst_n = 1'b0; pwm = 1'b0; wcke = 1'b0; wd = 32'h0; adrs = 16'h0;

        // 1: reset then idle
        repeat (5) cyc();
        chk("rst_vd", 32'(bus_vd), 32'd0);
        rst_n = 1'b1;
        cyc();
        bus_read({BLK, 8'h0C}, d);
        chk("stat_rst", d, 32'd0);
        cyc();
        chk("miss_vd", 32'(bus_vd), 32'd0);

        // 2: DTRISE=4, DTFALL=6, 50% PWM with period 40
        bus_write({BLK, 8'h04}, 32'd4);
        bus_write({BLK, 8'h08}, 32'd6);
        bus_write({BLK, 8'h00}, 32'd1);
        run = 0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 40; i++) begin
                pwm = (i < 20);
                cyc();
                if (p > 0) begin
                    if (!pwm_h && !pwm_l) run++;
                    else begin
                        if (run > 0 && pwm_h) chk("dead_rise", 32'(run), 32'd4);
                        if (run > 0 && pwm_l) chk("dead_fall", 32'(run), 32'd6);
                        run = 0;
                    end
                end
            end
        end

        // 3: short pulse swallowed
        bus_write({BLK, 8'h0C}, 32'd0);
        bus_write({BLK, 8'h04}, 32'd8);
        pwm = 1'b0;
        repeat (10) cyc();
        pwm = 1'b1;
        repeat (3) cyc();
        pwm = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            chk("swallow_h", 32'(pwm_h), 32'd0);
        end
        chk("swallow_l", 32'(pwm_l), 32'd1);
        bus_read({BLK, 8'h0C}, d);
        chk("stat_swallow", 32'(d[31:16]), 32'd1);

        // 4: disable in HIGH_ON, then re-enable with iPwm high
        pwm = 1'b1;
        repeat (15) cyc();
        chk("pre_dis_h", 32'(pwm_h), 32'd1);
        bus_write({BLK, 8'h00}, 32'd0);
        cyc();
        chk("dis_h", 32'(pwm_h), 32'd0);
        chk("dis_l", 32'(pwm_l), 32'd0);
        bus_write({BLK, 8'h00}, 32'd1);
        repeat (12) cyc();
        chk("reen_h", 32'(pwm_h), 32'd1);

        // 5: invert both legs with iPwm low
        pwm = 1'b0;
        bus_write({BLK, 8'h00}, 32'd7);
        repeat (12) cyc();
        chk("inv_h", 32'(pwm_h), 32'd1);
        chk("inv_l", 32'(pwm_l), 32'd0);
        bus_read({BLK, 8'h00}, d);
        chk("rd_ctrl", d, 32'd7);

        // unmapped offset and foreign block writes are ignored
        bus_write({BLK, 8'h10}, 32'h3FF);
        bus_write({8'h02, 8'h04}, 32'h3FF);
        bus_read({BLK, 8'h04}, d);
        chk("rd_dtrise", d, 32'd8);

        // 6: asynchronous reset in the middle of DEAD_LH
        bus_write({BLK, 8'h04}, 32'd20);
        pwm = 1'b1;
        repeat (5) cyc();
        chk("dead_inv_h", 32'(pwm_h), 32'd1);
        chk("dead_inv_l", 32'(pwm_l), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_h", 32'(pwm_h), 32'd0);
        chk("arst_l", 32'(pwm_l), 32'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        pwm = 1'b0;
        bus_read({BLK, 8'h00}, d);
        chk("arst_ctrl", d, 32'd0);
        bus_read({BLK, 8'h04}, d);
        chk("arst_dtrise", d, 32'd0);
        bus_read({BLK, 8'h0C}, d);
        chk("arst_stat", d, 32'd0);

        // randomized traffic against the reference model
        bus_write({BLK, 8'h04}, 32'd2);
        bus_write({BLK, 8'h08}, 32'd3);
        bus_write({BLK, 8'h00}, 32'd1);
        for (int k = 0; k < 400; k++) begin
            int act;
            int hold;
            act = $urandom_range(0, 15);
            case (act)
                0: bus_write({BLK, 8'h04}, 32'($urandom_range(0, 6)));
                1: bus_write({BLK, 8'h08}, 32'($urandom_range(0, 6)));
                2: bus_write({BLK, 8'h00}, {29'd0, 2'($urandom_range(0, 3)), ($urandom_range(0, 5) != 0)});
                3: bus_write({BLK, 8'h0C}, 32'd0);
                4: begin
                    bus_read({BLK, 8'h0C}, d);
                    chk("rnd_swallow", 32'(d[31:16]), 32'(m_sw_pre));
                end
                default: ;
            endcase
            pwm  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 12);
            repeat (hold) cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
